// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory bus controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [31:0] BAD_DATA_DEFAULT = 32'hDEADBEEF;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Free-running up counter with synchronous clear and a terminal-count flag.
module wait_counter #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] TC_VALUE = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TC_VALUE);

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-memory stage: turns datapath load/store strobes into req/gnt/rvalid
// bus transactions and stalls the processor until each access retires.
module dmem_bus_ctrl
  import dmem_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] BAD_DATA = BAD_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        misaligned,
  output logic        timeout_flag,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int            CW = 16;
  localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] readdata_q, readdata_d;
  logic        timeout_flag_q, timeout_flag_d;

  logic        access;
  logic        aligned;
  logic        stall_c;
  logic        misaligned_c;
  logic        cnt_clear;
  logic        cnt_en;
  logic        cnt_tc;

  assign access  = memread | memwrite;
  assign aligned = (addr[1:0] == 2'b00);

  wait_counter #(
    .WIDTH    (CW),
    .TC_VALUE (TC)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .tc     (cnt_tc)
  );

  always_comb begin
    state_d        = state_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;
    readdata_d     = readdata_q;
    timeout_flag_d = timeout_flag_q;
    stall_c        = 1'b0;
    misaligned_c   = 1'b0;
    cnt_clear      = 1'b0;
    cnt_en         = 1'b0;

    case (state_q)
      IDLE: begin
        if (access && aligned) begin
          stall_c     = 1'b1;
          cnt_clear   = 1'b1;
          bus_we_d    = memwrite;
          bus_addr_d  = word_align(addr);
          bus_wdata_d = wdata;
          state_d     = REQ;
        end else if (access) begin
          misaligned_c = 1'b1;
        end
      end

      // A read granted on its final allowed cycle still counts as a timeout.
      REQ: begin
        stall_c = 1'b1;
        cnt_en  = 1'b1;
        if (bus_gnt && bus_we_q) begin
          state_d = DONE;
        end else if (cnt_tc) begin
          state_d        = DONE;
          timeout_flag_d = 1'b1;
          if (!bus_we_q) begin
            readdata_d = BAD_DATA;
          end
        end else if (bus_gnt) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        stall_c = 1'b1;
        cnt_en  = 1'b1;
        if (bus_rvalid) begin
          readdata_d = bus_rdata;
          state_d    = DONE;
        end else if (cnt_tc) begin
          readdata_d     = BAD_DATA;
          timeout_flag_d = 1'b1;
          state_d        = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
      readdata_q     <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_wdata_q    <= bus_wdata_d;
      readdata_q     <= readdata_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign stall        = stall_c & ~reset;
  assign misaligned   = misaligned_c & ~reset;
  assign readdata     = misaligned ? 32'h0 : readdata_q;
  assign timeout_flag = timeout_flag_q;
  assign bus_req      = (state_q == REQ);
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Self-checking bench for dmem_bus_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_dmem_bus_ctrl;

  localparam int          TO  = 8;
  localparam logic [31:0] BAD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] readdata;
  logic        stall;
  logic        misaligned;
  logic        timeout_flag;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  int stall_cnt;
  int req_cnt;
  int rise_cnt;
  int retire_cnt;
  bit prev_req;

  dmem_bus_ctrl #(
    .TIMEOUT  (TO),
    .BAD_DATA (BAD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .memread      (memread),
    .memwrite     (memwrite),
    .addr         (addr),
    .wdata        (wdata),
    .readdata     (readdata),
    .stall        (stall),
    .misaligned   (misaligned),
    .timeout_flag (timeout_flag),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_gnt      (bus_gnt),
    .bus_rvalid   (bus_rvalid),
    .bus_rdata    (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the access in flight: whether one is outstanding, whether a read
  // has been granted, whether it is in its retire cycle, and cycles spent so far.
  bit          m_valid = 0;
  bit          m_busy, m_granted, m_finish, m_is_write, m_we, m_flag;
  int          m_elapsed;
  logic [31:0] m_addr, m_wdata, m_rdata;

  always @(negedge clk) begin : compare
    bit          acc, ok_align, e_mis, e_stall, e_req, done_ok;
    logic [31:0] e_rd;
    acc      = (memread || memwrite) && !reset;
    ok_align = (addr[1:0] == 2'b00);
    if (m_valid) begin
      e_mis   = !m_busy && acc && !ok_align;
      e_req   = m_busy && !m_finish && !m_granted;
      e_stall = !reset && !m_finish && (m_busy || (acc && ok_align));
      e_rd    = e_mis ? 32'h0 : m_rdata;
      check_output("stall", {31'h0, stall}, {31'h0, e_stall});
      check_output("misaligned", {31'h0, misaligned}, {31'h0, e_mis});
      check_output("bus_req", {31'h0, bus_req}, {31'h0, e_req});
      check_output("bus_we", {31'h0, bus_we}, {31'h0, m_we});
      check_output("bus_addr", bus_addr, m_addr);
      check_output("bus_wdata", bus_wdata, m_wdata);
      check_output("readdata", readdata, e_rd);
      check_output("timeout_flag", {31'h0, timeout_flag}, {31'h0, m_flag});
    end
    if (reset) begin
      m_valid = 1; m_busy = 0; m_finish = 0; m_granted = 0; m_is_write = 0;
      m_elapsed = 0; m_we = 0; m_flag = 0;
      m_addr = 0; m_wdata = 0; m_rdata = 0;
    end else if (m_finish) begin
      m_finish = 0;
      m_busy   = 0;
    end else if (m_busy) begin
      done_ok = m_is_write ? (!m_granted && bus_gnt) : (m_granted && bus_rvalid);
      if (done_ok) begin
        m_finish = 1;
        if (!m_is_write) m_rdata = bus_rdata;
      end else if (m_elapsed + 1 == TO) begin
        m_finish = 1;
        m_flag   = 1;
        if (!m_is_write) m_rdata = BAD;
      end else begin
        if (bus_gnt) m_granted = 1;
        m_elapsed++;
      end
    end else if (acc && ok_align) begin
      m_busy     = 1;
      m_granted  = 0;
      m_elapsed  = 0;
      m_is_write = memwrite;
      m_we       = memwrite;
      m_addr     = {addr[31:2], 2'b00};
      m_wdata    = wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic mr, input logic mw, input logic [31:0] a,
                                input logic [31:0] wd, input logic g, input logic rv,
                                input logic [31:0] rd);
    memread    = mr;
    memwrite   = mw;
    addr       = a;
    wdata      = wd;
    bus_gnt    = g;
    bus_rvalid = rv;
    bus_rdata  = rd;
    #2;
    if (stall) stall_cnt++;
    if (bus_req) req_cnt++;
    if (bus_req && !prev_req) rise_cnt++;
    if ((mr || mw) && !stall) retire_cnt++;
    prev_req = bus_req;
  endtask

  task automatic clear_counts();
    stall_cnt = 0; req_cnt = 0; rise_cnt = 0; retire_cnt = 0; prev_req = 0;
  endtask

  initial begin
    int gnt_p, rv_p, r;
    logic [31:0] a;
    reset = 1'b1;
    memread = 0; memwrite = 0; addr = 0; wdata = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    clear_counts();
    step();
    step();
    reset = 1'b0;

    $display("[TB] directed: aligned load");
    clear_counts();
    apply_stimulus(1, 0, 32'h40, 0, 0, 0, 0); step();
    apply_stimulus(1, 0, 32'h40, 0, 1, 0, 0);
    check_output("load_bus_we", {31'h0, bus_we}, 32'h0);
    check_output("load_bus_addr", bus_addr, 32'h40);
    step();
    apply_stimulus(1, 0, 32'h40, 0, 0, 0, 0); step();
    apply_stimulus(1, 0, 32'h40, 0, 0, 1, 32'h1234_5678); step();
    apply_stimulus(1, 0, 32'h40, 0, 0, 0, 0);
    check_output("load_done_data", readdata, 32'h1234_5678);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0); step();
    check_output("load_stall_cycles", stall_cnt, 4);

    $display("[TB] directed: store with late grant");
    clear_counts();
    apply_stimulus(0, 1, 32'h80, 32'hCAFE_F00D, 0, 0, 0); step();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 1, 32'h80, 32'hCAFE_F00D, 0, 0, 0); step();
    end
    apply_stimulus(0, 1, 32'h80, 32'hCAFE_F00D, 1, 0, 0);
    check_output("store_bus_addr", bus_addr, 32'h80);
    check_output("store_bus_wdata", bus_wdata, 32'hCAFE_F00D);
    check_output("store_bus_we", {31'h0, bus_we}, 32'h1);
    step();
    apply_stimulus(0, 1, 32'h80, 32'hCAFE_F00D, 0, 0, 0);
    check_output("store_keeps_readdata", readdata, 32'h1234_5678);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0); step();
    check_output("store_req_cycles", req_cnt, 4);
    check_output("store_retire_cycles", retire_cnt, 1);

    $display("[TB] directed: misaligned load");
    clear_counts();
    apply_stimulus(1, 0, 32'h42, 0, 0, 0, 0);
    check_output("mis_pulse", {31'h0, misaligned}, 32'h1);
    check_output("mis_readdata", readdata, 32'h0);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("mis_pulse_end", {31'h0, misaligned}, 32'h0);
    step();
    check_output("mis_stall_cycles", stall_cnt, 0);
    check_output("mis_req_cycles", req_cnt, 0);

    $display("[TB] directed: timeout");
    clear_counts();
    apply_stimulus(1, 0, 32'h100, 0, 0, 0, 0); step();
    for (int i = 0; i < TO; i++) begin
      apply_stimulus(1, 0, 32'h100, 0, 0, 0, 0); step();
    end
    apply_stimulus(1, 0, 32'h100, 0, 0, 0, 0);
    check_output("to_stall", {31'h0, stall}, 32'h0);
    check_output("to_readdata", readdata, 32'hDEAD_BEEF);
    check_output("to_flag", {31'h0, timeout_flag}, 32'h1);
    check_output("to_req_cycles", req_cnt, TO);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0); step();
    apply_stimulus(0, 1, 32'h10, 32'h5, 0, 0, 0); step();
    apply_stimulus(0, 1, 32'h10, 32'h5, 1, 0, 0); step();
    apply_stimulus(0, 1, 32'h10, 32'h5, 0, 0, 0); step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("to_flag_sticky", {31'h0, timeout_flag}, 32'h1);
    step();

    $display("[TB] directed: back-to-back store then load");
    clear_counts();
    apply_stimulus(0, 1, 32'h84, 32'h1111, 0, 0, 0); step();
    apply_stimulus(0, 1, 32'h84, 32'h1111, 1, 0, 0); step();
    apply_stimulus(0, 1, 32'h84, 32'h1111, 0, 0, 0); step();
    apply_stimulus(1, 0, 32'h88, 0, 0, 0, 0);
    check_output("b2b_idle_stall", {31'h0, stall}, 32'h1);
    step();
    apply_stimulus(1, 0, 32'h88, 0, 1, 0, 0); step();
    apply_stimulus(1, 0, 32'h88, 0, 0, 1, 32'h55AA_55AA); step();
    apply_stimulus(1, 0, 32'h88, 0, 0, 0, 0);
    check_output("b2b_load_data", readdata, 32'h55AA_55AA);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0); step();
    check_output("b2b_req_rises", rise_cnt, 2);
    check_output("b2b_req_cycles", req_cnt, 2);

    $display("[TB] directed: reset during WAIT");
    apply_stimulus(1, 0, 32'h8C, 0, 0, 0, 0); step();
    apply_stimulus(1, 0, 32'h8C, 0, 1, 0, 0); step();
    reset = 1'b1;
    apply_stimulus(1, 0, 32'h8C, 0, 0, 0, 0); step();
    reset = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    check_output("rst_bus_req", {31'h0, bus_req}, 32'h0);
    check_output("rst_stall", {31'h0, stall}, 32'h0);
    check_output("rst_readdata", readdata, 32'h0);
    check_output("rst_flag", {31'h0, timeout_flag}, 32'h0);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("rst_late_rvalid", readdata, 32'h0);
    step();

    $display("[TB] randomized traffic");
    gnt_p = 50;
    rv_p  = 50;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 64 == 0) begin
        r = $urandom_range(0, 3);
        gnt_p = (r == 0) ? 0 : (r == 1) ? 25 : (r == 2) ? 60 : 100;
        rv_p  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(20, 100);
      end
      reset = ($urandom_range(0, 299) == 0);
      r = $urandom_range(0, 9);
      a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      apply_stimulus(r >= 4 && r != 7 && r != 8, r >= 7, a, $urandom,
                     $urandom_range(0, 99) < gnt_p, $urandom_range(0, 99) < rv_p,
                     $urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
